// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the CPU fetch port.
// Accepts one byte-addressed fetch at a time over a valid/ready request
// channel and answers after LATENCY cycles with the instruction word (or a
// fault flag) over a valid/ready response channel. The word array is filled
// through an independent load port.
module instr_mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int         WORDS    = 1 << DEPTH_LOG2;
    // Counter preload: WAIT spends LATENCY-1 cycles counting down, then one
    // more cycle capturing, so rsp_valid rises LATENCY edges after acceptance.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [31:0]     addr_reg, addr_next;
    logic            rsp_valid_reg, rsp_valid_next;
    logic            capture;
    logic [31:0]     rsp_instr_reg;
    logic            rsp_err_reg;

    logic [31:0]     mem [WORDS];

    logic                  misaligned;
    logic                  out_of_range;
    logic [DEPTH_LOG2-1:0] rd_idx;

    // Decode of the latched fetch address; both fault kinds map to one bit.
    assign misaligned   = (addr_reg[1:0] != 2'b00);
    assign out_of_range = (addr_reg[31:DEPTH_LOG2+2] != '0);
    assign rd_idx       = addr_reg[DEPTH_LOG2+1:2];

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_instr = rsp_instr_reg;
    assign rsp_err   = rsp_err_reg;

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        rsp_valid_next = rsp_valid_reg;
        capture        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    addr_next  = req_addr;
                    cnt_next   = CNT_INIT;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    capture        = 1'b1;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state register; reset drops any in-flight request.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            addr_reg      <= 32'd0;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

    // Registered array read at the capture edge. A load to the same word on
    // that edge lands after this read, so the response carries the old word.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rsp_instr_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else if (capture) begin
            if (misaligned || out_of_range) begin
                rsp_instr_reg <= 32'd0;
                rsp_err_reg   <= 1'b1;
            end else begin
                rsp_instr_reg <= mem[rd_idx];
                rsp_err_reg   <= 1'b0;
            end
        end
    end

    // Load port: array contents survive reset, but writes during reset are dropped.
    always_ff @(posedge Clock) begin
        if (Reset && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (LATENCY=2 and LATENCY=1)
// share clock, reset and load port. A per-cycle monitor pushes expected
// responses on request acceptance and pops/compares them on response handshake.
module tb_instr_mem_responder;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_addr [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_instr [2];
    logic [1:0]  rsp_err;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    int          n_vec = 0;
    int          n_bad = 0;
    int          edge_n = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        nxt [2];
    logic [1:0]  prev_valid;
    logic [1:0]  accepted;
    int          acc_edge [2];
    int          acc_cnt [2];
    int          rsp_cnt [2];
    int          lat [2];
    logic [31:0] mdl [256];
    vec_t        tbl [8];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            instr_mem_responder #(
                .DEPTH_LOG2(8),
                .LATENCY   ((gi == 0) ? 2 : 1)
            ) dut (
                .Clock    (Clock),
                .Reset    (Reset),
                .req_valid(req_valid[gi]),
                .req_ready(req_ready[gi]),
                .req_addr (req_addr[gi]),
                .rsp_valid(rsp_valid[gi]),
                .rsp_ready(rsp_ready[gi]),
                .rsp_instr(rsp_instr[gi]),
                .rsp_err  (rsp_err[gi]),
                .load_en  (load_en),
                .load_addr(load_addr),
                .load_data(load_data)
            );
        end
    endgenerate

    always #5 Clock = ~Clock;

    always @(posedge Clock) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Sampled on the falling edge: predicts what the next rising edge does.
    task automatic monitor();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!Reset) begin
                acc_cnt[d] -= qsize(d);
                if (d == 0) q0.delete(); else q1.delete();
                prev_valid[d] = 1'b0;
            end else begin
                if (rsp_valid[d] && !prev_valid[d])
                    chk($sformatf("latency_dut%0d", d), edge_n - acc_edge[d], lat[d]);
                if (rsp_valid[d] && rsp_ready[d]) begin
                    rsp_cnt[d]++;
                    if (qsize(d) == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_rsp_dut%0d: got instr %h, required no response", d, rsp_instr[d]);
                    end else begin
                        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk($sformatf("rsp_instr_dut%0d", d), rsp_instr[d], e.instr);
                        chk1($sformatf("rsp_err_dut%0d", d), rsp_err[d], e.err);
                        $display("dut%0d rsp instr=%h err=%b", d, rsp_instr[d], rsp_err[d]);
                    end
                end
                if (req_valid[d] && req_ready[d]) begin
                    acc_edge[d] = edge_n + 1;
                    acc_cnt[d]++;
                    accepted[d] = 1'b1;
                    if (d == 0) q0.push_back(nxt[d]); else q1.push_back(nxt[d]);
                end
                prev_valid[d] = rsp_valid[d];
            end
        end
    endtask

    task automatic step();
        @(negedge Clock);
        monitor();
        @(posedge Clock);
        #1;
    endtask

    task automatic send(input int d, input logic [31:0] addr, input logic [31:0] instr, input logic err);
        req_addr[d]   = addr;
        nxt[d].instr  = instr;
        nxt[d].err    = err;
        req_valid[d]  = 1'b1;
        accepted[d]   = 1'b0;
        for (int i = 0; i < 50 && !accepted[d]; i++) step();
        req_valid[d]  = 1'b0;
        if (!accepted[d]) fail_now($sformatf("accept_timeout_dut%0d", d));
    endtask

    task automatic wait_rsp(input int d, input bit rnd);
        int start;
        start = rsp_cnt[d];
        for (int i = 0; i < 100 && rsp_cnt[d] == start; i++) begin
            if (rnd) rsp_ready[d] = 1'($urandom_range(0, 1));
            step();
        end
        rsp_ready[d] = 1'b1;
        if (rsp_cnt[d] == start) fail_now($sformatf("rsp_timeout_dut%0d", d));
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] v);
        load_en   = 1'b1;
        load_addr = a;
        load_data = v;
        mdl[a]    = v;
        step();
        load_en   = 1'b0;
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        tbl[0] = '{32'h0000_0000, 32'h8C01_0004, 1'b0};
        tbl[1] = '{32'h0000_0004, 32'hAC02_0008, 1'b0};
        tbl[2] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
        tbl[3] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
        tbl[4] = '{32'h0000_03FC, 32'hDEAD_BEEF, 1'b0};
        tbl[5] = '{32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[6] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[7] = '{32'h0000_0008, 32'h1111_1111, 1'b0};

        req_valid  = 2'b00;
        rsp_ready  = 2'b11;
        req_addr[0] = 32'd0;
        req_addr[1] = 32'd0;
        load_en    = 1'b0;
        load_addr  = 8'd0;
        load_data  = 32'd0;
        prev_valid = 2'b00;
        accepted   = 2'b00;
        for (int d = 0; d < 2; d++) begin
            acc_edge[d] = 0;
            acc_cnt[d]  = 0;
            rsp_cnt[d]  = 0;
        end

        // Reset state.
        step();
        step();
        Reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk1($sformatf("reset_req_ready_dut%0d", d), req_ready[d], 1'b1);
            chk1($sformatf("reset_rsp_valid_dut%0d", d), rsp_valid[d], 1'b0);
            chk($sformatf("reset_rsp_instr_dut%0d", d), rsp_instr[d], 32'd0);
            chk1($sformatf("reset_rsp_err_dut%0d", d), rsp_err[d], 1'b0);
        end

        load(8'd0, 32'h8C01_0004);
        load(8'd1, 32'hAC02_0008);
        load(8'd2, 32'h1111_1111);
        load(8'd255, 32'hDEAD_BEEF);
        for (int i = 3; i < 16; i++) load(8'(i), $urandom);

        // Table of fetches on both latencies.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                send(d, tbl[i].addr, tbl[i].instr, tbl[i].err);
                wait_rsp(d, 1'b0);
            end
        end

        // Backpressure: response held, extra request ignored.
        rsp_ready[0] = 1'b0;
        send(0, 32'h4, 32'hAC02_0008, 1'b0);
        for (int i = 0; i < 20 && !rsp_valid[0]; i++) step();
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h10;
        for (int i = 0; i < 5; i++) begin
            chk1("bp_rsp_valid", rsp_valid[0], 1'b1);
            chk("bp_rsp_instr", rsp_instr[0], 32'hAC02_0008);
            chk1("bp_req_ready", req_ready[0], 1'b0);
            step();
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        chk1("bp_req_ready_at_hs", req_ready[0], 1'b0);
        step();
        chk1("bp_req_ready_after", req_ready[0], 1'b1);
        chk1("bp_rsp_valid_after", rsp_valid[0], 1'b0);
        chk("bp_rsp_instr_hold", rsp_instr[0], 32'hAC02_0008);

        // Collision: load to the fetched word on the capture edge.
        send(0, 32'h8, 32'h1111_1111, 1'b0);
        step();
        load(8'd2, 32'h2222_2222);
        wait_rsp(0, 1'b0);
        send(0, 32'h8, 32'h2222_2222, 1'b0);
        wait_rsp(0, 1'b0);

        // Reset in WAIT drops the request; a load during reset is ignored.
        send(0, 32'h0, 32'h8C01_0004, 1'b0);
        Reset     = 1'b0;
        load_en   = 1'b1;
        load_addr = 8'd0;
        load_data = 32'hFFFF_FFFF;
        step();
        Reset   = 1'b1;
        load_en = 1'b0;
        chk1("rst_mid_req_ready", req_ready[0], 1'b1);
        chk("rst_mid_rsp_instr", rsp_instr[0], 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk1("rst_mid_no_rsp", rsp_valid[0], 1'b0);
            step();
        end
        send(0, 32'h0, 32'h8C01_0004, 1'b0);
        wait_rsp(0, 1'b0);

        // LATENCY=1 sequential PC sweep with random response backpressure.
        for (int i = 0; i < 16; i++) begin
            send(1, 32'(i * 4), mdl[i], 1'b0);
            wait_rsp(1, 1'b1);
        end

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rsp_count_dut%0d", d), rsp_cnt[d], acc_cnt[d]);
            chk($sformatf("pending_dut%0d", d), qsize(d), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
